// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters.
// One operation in flight: capture operands, execute one cycle, hold the result for its owner.
module alu_share_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DATA_W-1:0]  req_in1,
  input  logic [N_REQ*DATA_W-1:0]  req_in2,
  input  logic [N_REQ*FUNC_W-1:0]  req_func,
  output logic [DATA_W-1:0]        alu_in1,
  output logic [DATA_W-1:0]        alu_in2,
  output logic [FUNC_W-1:0]        alu_func,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_zero,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_zero,
  output logic                     busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] owner_q;

  // Per-requester views of the packed operand buses.
  logic [DATA_W-1:0] in1_arr  [N_REQ];
  logic [DATA_W-1:0] in2_arr  [N_REQ];
  logic [FUNC_W-1:0] func_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign in1_arr[g]  = req_in1[g*DATA_W +: DATA_W];
    assign in2_arr[g]  = req_in2[g*DATA_W +: DATA_W];
    assign func_arr[g] = req_func[g*FUNC_W +: FUNC_W];
  end

  // Round-robin search: rotate valids so the rr pointer sits at bit 0, take the lowest set bit.
  logic [N_REQ-1:0] valid_rot;
  logic             win_found;
  logic [IDX_W:0]   win_sum;
  logic [IDX_W-1:0] win_idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_rot = N_REQ'({req_valid, req_valid} >> rr_q);
    win_found = 1'b0;
    win_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_q} + (IDX_W+1)'(k);
      end
    end
    win_idx = (win_sum >= N_REQ_W) ? IDX_W'(win_sum - N_REQ_W) : IDX_W'(win_sum);
  end

  // Arbitration is open when idle, or in the cycle the current owner takes its result.
  logic rsp_done;
  logic arb_en;
  logic accept;

  assign rsp_done  = (state_q == S_RESP) && rsp_ready[owner_q];
  assign arb_en    = (state_q == S_IDLE) || rsp_done;
  assign accept    = arb_en && win_found;
  assign req_ready = accept ? (N_REQ'(1) << win_idx) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (N_REQ'(1) << owner_q) : '0;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_done) state_d = accept ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= win_idx;
        rr_q    <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // NOTE: the datapath registers are reset too, because their reset value is visible on the ALU and response ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_func <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      // Operand registers feed the ALU directly and keep their value until the next accept.
      if (accept) begin
        alu_in1  <= in1_arr[win_idx];
        alu_in2  <= in2_arr[win_idx];
        alu_func <= func_arr[win_idx];
      end
      if (state_q == S_EXEC) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
      end
    end
  end

endmodule
